// File: rtl/divres_bcd.sv
// rtl/divres_bcd.sv - sequential double-dabble binary-to-BCD converter behind the divider core
// Optional leading-zero blanking of the result: define DIVRES_BCD_LZB_EN.
module divres_bcd #(
   parameter int NBITS   = 32,
   parameter int NDIGITS = 10
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   div_busy,
   input  logic                   start,
   input  logic [NBITS-1:0]       binin,
   output logic                   busy,
   output logic                   done,
   output logic [4*NDIGITS-1:0]   bcd
);

   localparam int CW = $clog2(NBITS + 1);
   localparam int WW = 4 * NDIGITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            r_state;
   logic              r_div_busy_d;
   logic [NBITS-1:0]  r_bin_sr;
   logic [WW-1:0]     r_work;
   logic [CW-1:0]     r_cnt;
   logic              r_busy;
   logic              r_done;
   logic [WW-1:0]     r_bcd;

   logic              w_trig;
   logic [WW-2:0]     w_adj;
   logic [WW-1:0]     w_work_nxt;
   logic [NBITS-1:0]  w_bin_nxt;
   logic [WW-1:0]     w_bcd_nxt;

   assign w_trig = start | (r_div_busy_d & ~div_busy);

   // The top bit of the adjusted accumulator is shifted out, so the top digit is only added on 3 bits.
   always_comb begin
      w_adj = r_work[WW-2:0];
      for (int i = 0; i < NDIGITS - 1; i++) begin
         if (r_work[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
         end
      end
      if (r_work[WW-1 -: 4] >= 4'd5) begin
         w_adj[WW-2 -: 3] = r_work[WW-2 -: 3] + 3'd3;
      end
   end

   assign w_work_nxt = {w_adj, r_bin_sr[NBITS-1]};
   assign w_bin_nxt  = {r_bin_sr[NBITS-2:0], 1'b0};

`ifdef DIVRES_BCD_LZB_EN
   always_comb begin : blank
      logic v_lead;
      v_lead    = 1'b1;
      w_bcd_nxt = w_work_nxt;
      for (int i = NDIGITS - 1; i >= 1; i--) begin
         if (v_lead && (w_work_nxt[4*i +: 4] == 4'd0)) begin
            w_bcd_nxt[4*i +: 4] = 4'hF;
         end else begin
            v_lead = 1'b0;
         end
      end
   end
`else
   assign w_bcd_nxt = w_work_nxt;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_div_busy_d <= 1'b0;
         r_bin_sr     <= '0;
         r_work       <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_bcd        <= '0;
      end else begin
         r_div_busy_d <= div_busy;
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (w_trig) begin
                  r_bin_sr <= binin;
                  r_work   <= '0;
                  r_cnt    <= CW'(NBITS);
                  r_busy   <= 1'b1;
                  r_state  <= S_SHIFT;
               end else begin
                  r_busy   <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_work   <= w_work_nxt;
               r_bin_sr <= w_bin_nxt;
               r_cnt    <= r_cnt - CW'(1);
               // Last step: publish the finished accumulator in the same edge it is formed.
               if (r_cnt == CW'(1)) begin
                  r_bcd   <= w_bcd_nxt;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign bcd  = r_bcd;

endmodule

// File: doc/divres_bcd.md
# divres_bcd

Sequential binary-to-BCD converter that sits directly downstream of the divider core. It consumes the divider's quotient (or any NBITS binary word) and produces NDIGITS packed BCD digits using shift-and-add-3 (double-dabble), one bit per clock. It starts automatically when the divider's busy flag falls, or on an explicit start pulse. The BCD result feeds ioports input ports and the board display logic.

## Interface

Parameters:
- NBITS, 32, width of the binary input.
- NDIGITS, 10, number of BCD output digits; must satisfy 10^NDIGITS > 2^NBITS - 1.

Ports:
- clock  input  1  master clock (100 MHz); single clock domain.
- reset  input  1  synchronous reset, active high.
- div_busy  input  1  divider busy flag; a 1→0 transition triggers a conversion.
- start  input  1  manual trigger, sampled at clock edge; level or pulse.
- binin  input  NBITS  binary value to convert; sampled only on the trigger edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*NDIGITS  packed BCD result; digit 0 is in bits [3:0]. Holds its value until the next done.

## Operation

- Internal state:
  - div_busy_d: registered copy of div_busy.
  - bin_sr: NBITS shift register.
  - work: 4*NDIGITS accumulator.
  - cnt: bit counter, at least clog2(NBITS+1) wide.
- FSM has three states: IDLE, SHIFT, DONE.
- trig = start | (div_busy_d & ~div_busy).
- Triggers are accepted only in IDLE or DONE. In SHIFT, triggers are ignored and not queued.
- On an accepted trigger:
  - bin_sr ← binin, work ← 0, cnt ← NBITS.
  - Go to SHIFT.
- SHIFT, one step per cycle:
  - Every digit of work that is ≥ 5 gets +3 (4-bit add; no carry out of the digit).
  - Then {work, bin_sr} shifts left by 1.
  - cnt decrements. When cnt reaches 1 before the decrement, go to DONE.
- DONE:
  - bcd ← work (after optional blanking, see Configuration).
  - done = 1 for this cycle only.
  - If a trigger is present in this cycle, start a new conversion (back-to-back). Otherwise go to IDLE.
- busy = 1 in SHIFT, 0 in IDLE and DONE.
- A start and a div_busy falling edge in the same cycle produce exactly one conversion.
- Conversion is exact for any binin in [0, 2^NBITS−1]. The most significant digit never exceeds 9.

## Timing

- Reset values:
  - State IDLE.
  - busy=0, done=0, bcd=0.
  - div_busy_d=0, cnt=0, bin_sr=0, work=0.
- Reset asserted mid-conversion aborts the conversion immediately:
  - bcd clears to 0.
  - No done pulse is produced.
  - A trigger present in the reset cycle is ignored.
- Trigger sampled at edge E:
  - busy is high after E.
  - SHIFT occupies edges E+1 … E+NBITS.
  - At edge E+NBITS the FSM enters DONE: bcd updates and done=1 (busy=0) during the cycle after E+NBITS.
  - Latency is NBITS+1 cycles from trigger edge to done (33 for NBITS=32).
- div_busy falls after edge k:
  - Falling edge is detected and binin captured at edge k+1.
  - binin must be valid (divider quotient stable) in the cycle in which div_busy is low.
- div_busy held low after reset does not trigger, because div_busy_d resets to 0.
- Back-to-back: a trigger accepted in DONE starts the next conversion with no idle cycle. Minimum period is NBITS+1 cycles.

## Configuration

- DIVRES_BCD_LZB_EN: leading-zero blanking.
- Defined:
  - At the DONE update, every digit above the most significant nonzero digit is written as 4'hF.
  - Digit 0 is never blanked. Value 0 gives digit0=0 and all other digits F.
- Undefined: bcd = work unchanged; leading zeros remain 4'h0.
- FSM, latency and handshake are identical in both builds.

## Test plan

- NBITS=32, reset, start pulse with binin=0 → done 33 cycles later; bcd=40'h0000000000 (LZB off) or 40'hFFFFFFFFF0 (LZB on).
- start with binin=32'hFFFFFFFF → bcd=40'h4294967295; busy high for exactly 32 cycles.
- div_busy held 1 for 5 cycles, then 0 with binin=12345 → conversion starts the edge after the fall; bcd=40'h0000012345 (LZB off) or 40'hFFFFF12345 (LZB on).
- start pulses at cycles 3 and 10 after the first trigger while busy → ignored; exactly one done. A start in the DONE cycle with binin=999 → second done 33 cycles later, bcd=…0999.
- reset asserted at cycle 15 of a conversion → bcd=0, busy=0, no done. A start after reset release with binin=100 → bcd=…0100.
- start and div_busy fall in the same cycle with binin=7 → single done; bcd digit0=7.
